// File: rtl/control_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : control_pipeline
// Purpose  : Carries decoded MIPS control through the ID/EX, EX/MEM and
//            MEM/WB boundaries. Inserts a bubble into EX on a load-use stall
//            and squashes EX and MEM on a taken branch.
// Options  : CTRL_PIPE_PERF_EN adds saturating stall and flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module control_pipeline #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid_i,
  input  logic                    reg_dst_i,
  input  logic                    alu_src_i,
  input  logic                    mem_to_reg_i,
  input  logic                    reg_write_i,
  input  logic                    mem_read_i,
  input  logic                    mem_write_i,
  input  logic                    branch_ne_i,
  input  logic                    branch_eq_i,
  input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic                    ex_valid_o,
  output logic                    ex_reg_dst_o,
  output logic                    ex_alu_src_o,
  output logic [ALU_OP_WIDTH-1:0] ex_alu_op_o,
  output logic                    ex_mem_read_o,
  output logic                    ex_reg_write_o,
  output logic                    mem_valid_o,
  output logic                    mem_mem_read_o,
  output logic                    mem_mem_write_o,
  output logic                    mem_branch_eq_o,
  output logic                    mem_branch_ne_o,
  output logic                    mem_reg_write_o,
  output logic                    wb_valid_o,
  output logic                    wb_mem_to_reg_o,
  output logic                    wb_reg_write_o
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]    stall_cnt_o,
  output logic [CNT_WIDTH-1:0]    flush_cnt_o
`endif
);

  // Full control word held in ID/EX; branch/memory/write-back fields ride
  // along even though EX itself only exposes a subset.
  typedef struct packed {
    logic                    valid;
    logic                    reg_dst;
    logic                    alu_src;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    branch_ne;
    logic                    branch_eq;
    logic [ALU_OP_WIDTH-1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_to_reg;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch_ne;
    logic branch_eq;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  ex_ctrl_t  ex_d,  ex_q;
  mem_ctrl_t mem_d, mem_q;
  wb_ctrl_t  wb_d,  wb_q;

  // Next-state for all three stage registers. A bubble is an all-zero word,
  // so the "no write from a bubble" invariant holds by construction and is
  // simply propagated downstream.
  always_comb begin
    ex_d  = '0;
    mem_d = '0;
    wb_d  = '0;

    // ID/EX: flush outranks stall; both, or an empty ID slot, give a bubble.
    if (!flush_i && !stall_i && id_valid_i) begin
      ex_d.valid      = 1'b1;
      ex_d.reg_dst    = reg_dst_i;
      ex_d.alu_src    = alu_src_i;
      ex_d.mem_to_reg = mem_to_reg_i;
      ex_d.reg_write  = reg_write_i;
      ex_d.mem_read   = mem_read_i;
      ex_d.mem_write  = mem_write_i;
      ex_d.branch_ne  = branch_ne_i;
      ex_d.branch_eq  = branch_eq_i;
      ex_d.alu_op     = alu_op_i;
    end

    // EX/MEM: squashed only by a taken branch (the instruction in EX is on
    // the wrong path); a stall does not hold EX, it only bubbles behind it.
    if (!flush_i) begin
      mem_d.valid      = ex_q.valid;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.branch_ne  = ex_q.branch_ne;
      mem_d.branch_eq  = ex_q.branch_eq;
    end

    // MEM/WB: unconditional; the resolving branch itself must complete.
    wb_d.valid      = mem_q.valid;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.reg_write  = mem_q.reg_write;
  end

  // Stage registers; async reset drops all in-flight control at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Outputs come straight from the stage registers.
  always_comb begin
    ex_valid_o      = ex_q.valid;
    ex_reg_dst_o    = ex_q.reg_dst;
    ex_alu_src_o    = ex_q.alu_src;
    ex_alu_op_o     = ex_q.alu_op;
    ex_mem_read_o   = ex_q.mem_read;
    ex_reg_write_o  = ex_q.reg_write;
    mem_valid_o     = mem_q.valid;
    mem_mem_read_o  = mem_q.mem_read;
    mem_mem_write_o = mem_q.mem_write;
    mem_branch_eq_o = mem_q.branch_eq;
    mem_branch_ne_o = mem_q.branch_ne;
    mem_reg_write_o = mem_q.reg_write;
    wb_valid_o      = wb_q.valid;
    wb_mem_to_reg_o = wb_q.mem_to_reg;
    wb_reg_write_o  = wb_q.reg_write;
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_d, flush_cnt_q;

  // Saturating event counters. A stall only counts when it actually bubbles
  // a real instruction and is not overridden by a flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_i && !flush_i && id_valid_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_i && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared with the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
`default_nettype wire
